// File: rtl/adder_pkg.sv
// adder_pkg: shared width constant and operand/sum types for the registered adder
// ADD_W  default operand width
// opnd_t operand of ADD_W bits
// sum_t  sum of ADD_W+1 bits (carry in the top bit)
package adder_pkg;
    localparam int ADD_W = 4;
    typedef logic [ADD_W-1:0] opnd_t;
    typedef logic [ADD_W:0]   sum_t;
endpackage

// File: rtl/four_bits_adder_full_adder.sv
// full_adder: one-bit full adder cell for the ripple-carry chain
// x, y  operand bits
// ci    carry in
// sum   sum bit
// co    carry out
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic sum,
    output logic co
);
    logic p;
    assign p   = x ^ y;
    assign sum = p ^ ci;
    assign co  = (x & y) | (ci & p);
endmodule

// File: rtl/four_bits_adder.sv
// four_bits_adder: registered ripple-carry adder with carry-out and signed-overflow flags
// clk    rising-edge clock
// rst_n  asynchronous active-low reset
// en     operand load enable
// a, b   WIDTH-bit operands
// s      WIDTH+1-bit registered sum, s[WIDTH] is the carry
// c      registered carry-out of the MSB
// o      registered two's-complement overflow
// valid  high for the cycle after each en=1 sample
module four_bits_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   s,
    output logic             c,
    output logic             o,
    output logic             valid
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_n;
    logic             ovf;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d, o_q, o_d, valid_q, valid_d;
    assign carry[0] = 1'b0;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .x  (a[i]),
            .y  (b[i]),
            .ci (carry[i]),
            .sum(sum_n[i]),
            .co (carry[i+1])
        );
    end
    // Signed overflow: carry into the MSB differs from carry out of it.
    assign ovf = carry[WIDTH] ^ carry[WIDTH-1];
    // Operands are ignored entirely when en=0, so X there cannot leak out.
    always_comb begin
        sum_d   = en ? sum_n : sum_q;
        c_d     = en ? carry[WIDTH] : c_q;
        o_d     = en ? ovf : o_q;
        valid_d = en;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            c_q     <= 1'b0;
            o_q     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            c_q     <= c_d;
            o_q     <= o_d;
            valid_q <= valid_d;
        end
    end
    // The top sum bit is the carry register itself, so s[WIDTH]==c by construction.
    assign s     = {c_q, sum_q};
    assign c     = c_q;
    assign o     = o_q;
    assign valid = valid_q;
endmodule

// File: tb/tb_four_bits_adder.sv
// tb_four_bits_adder: directed and randomized checks of four_bits_adder against an arithmetic model
module tb_four_bits_adder;
    localparam int W = 4;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic [W:0]   s;
    logic         c, o, valid;
    int           n_chk = 0, n_pass = 0;
    int           m_s = 0, m_c = 0, m_o = 0, m_v = 0;

    four_bits_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b),
        .s(s), .c(c), .o(o), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: plain integer arithmetic on unsigned and signed views of the operands.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s = 0; m_c = 0; m_o = 0; m_v = 0;
        end else begin
            m_v = en;
            if (en) begin
                int sa, sb, sr;
                m_s = int'(a) + int'(b);
                m_c = m_s >= (1 << W) ? 1 : 0;
                sa = int'(a) >= (1 << (W-1)) ? int'(a) - (1 << W) : int'(a);
                sb = int'(b) >= (1 << (W-1)) ? int'(b) - (1 << W) : int'(b);
                sr = sa + sb;
                m_o = (sr > (1 << (W-1)) - 1 || sr < -(1 << (W-1))) ? 1 : 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_s", int'(s), m_s);
        chk("model_c", int'(c), m_c);
        chk("model_o", int'(o), m_o);
        chk("model_valid", int'(valid), m_v);
    end

    task automatic step(input logic e, input int av, input int bv,
                        input int es, input int ec, input int eo, input int ev);
        @(negedge clk);
        en = e; a = W'(av); b = W'(bv);
        @(posedge clk);
        #1;
        chk("lit_s", int'(s), es);
        chk("lit_c", int'(c), ec);
        chk("lit_o", int'(o), eo);
        chk("lit_valid", int'(valid), ev);
    endtask

    initial begin
        en = 1'b1; a = 4'b1011; b = 4'b0110;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_s", int'(s), 0);
            chk("rst_valid", int'(valid), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 4'b0000, 4'b0000, 5'b00000, 0, 0, 1);
        step(1'b1, 4'b0000, 4'b0001, 5'b00001, 0, 0, 1);
        step(1'b1, 4'b1010, 4'b0101, 5'b01111, 0, 0, 1);
        step(1'b1, 4'b1100, 4'b1101, 5'b11001, 1, 0, 1);
        step(1'b1, 4'b0111, 4'b0010, 5'b01001, 0, 1, 1);
        step(1'b1, 4'b0111, 4'b0101, 5'b01100, 0, 1, 1);
        step(1'b1, 4'b1000, 4'b1000, 5'b10000, 1, 1, 1);
        step(1'b0, 4'b1111, 4'b1111, 5'b10000, 1, 1, 0);
        step(1'b0, 4'b1111, 4'b1111, 5'b10000, 1, 1, 0);
        step(1'b1, 4'b1111, 4'b1111, 5'b11110, 1, 0, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_s", int'(s), 0);
        chk("async_c", int'(c), 0);
        chk("async_o", int'(o), 0);
        chk("async_valid", int'(valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
        step(1'b0, 4'b1111, 4'b0001, 0, 0, 0, 0);
        step(1'b1, 4'b1001, 4'b0011, 5'b01100, 0, 0, 1);
        repeat (400) begin
            @(negedge clk);
            en = $urandom_range(0, 3) != 0;
            a = W'($urandom);
            b = W'($urandom);
        end
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
